layer1_window_gen: RTL and testbench
====================================

# layer1_window_gen

Streaming 3x3 sliding-window generator for the layer-1 CNN datapath. It is the read side of the layer-1 line-delay stage. It accepts a raster-ordered pixel stream through a valid/ready handshake and keeps the previous two image rows in internal line buffers. For every pixel position where a full 3x3 neighbourhood exists, it emits one packed window under its own valid/ready handshake. The conv/PE array sits downstream; the pixel fetch unit sits upstream.

## Interface
Parameters:
- DATA_W, 16, bits per pixel
- IMG_W, 32, pixels per row (>= 3)
- IMG_H, 32, rows per frame (>= 3)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, synchronous, active-low
- in_valid  input  1  pixel present on in_data
- in_data  input  DATA_W  pixel value
- in_ready  output  1  block can take a pixel this cycle
- win_valid  output  1  win_data holds a valid window
- win_data  output  9*DATA_W  packed 3x3 window
- win_ready  input  1  downstream consumes the window this cycle
- frame_done  output  1  one-cycle pulse when the last pixel of a frame is accepted
- win_row  output  $clog2(IMG_H)  row of the window's bottom-right pixel (WIN_POS_EN only)
- win_col  output  $clog2(IMG_W)  column of the window's bottom-right pixel (WIN_POS_EN only)

## Operation
- **Accept rule:** a pixel is accepted when in_valid && in_ready. Pixels arrive in raster order: col 0..IMG_W-1, then the next row.
- **Position counters:**
  - col/row count accepted pixels.
  - col wraps IMG_W-1 -> 0 and increments row.
  - row wraps IMG_H-1 -> 0 at the end of the frame.
- **Line buffers:** two arrays lb0 (row r-1) and lb1 (row r-2), IMG_W entries each, indexed by col. On accept at column c, in the same edge:
  - lb1[c] <= lb0[c]
  - lb0[c] <= in_data
  - the 3x3 window register shifts one column left and loads the new right column {lb1[c], lb0[c], in_data} (top to bottom).
- **Window emission:**
  - An accepted pixel at (r,c) with r >= 2 and c >= 2 sets win_valid and loads win_data.
  - Other accepted pixels update buffers and counters only, with no window.
  - Windows per frame: (IMG_W-2)*(IMG_H-2).
- **Window packing:**
  - Element index k = 3*i + j; i = 0 is the oldest row, j = 0 is the leftmost column.
  - Element k occupies bits [(k+1)*DATA_W-1 : k*DATA_W].
- **No clearing between frames:** line-buffer contents are not cleared. Stale data never reaches the output because windows at r < 2 or c < 2 are masked.
- **Backpressure:**
  - in_ready = rst && (!win_valid || win_ready).
  - While win_valid && !win_ready, win_data, win_valid and any position outputs hold stable, and no pixel is accepted.
- **frame_done:** pulses for one cycle on the edge that accepts pixel (IMG_H-1, IMG_W-1). Counters return to (0,0) on the same edge.
- **Reset (rst low at a rising edge):**
  - col, row, win_valid, frame_done and the window register go to 0; win_data reads 0.
  - Line-buffer RAM is not reset.
  - A reset mid-frame discards the partial frame. The next accepted pixel is treated as (0,0).

## Timing
- Latency: the window appears on the clock edge that accepts its bottom-right pixel, so win_valid is high in the following cycle.
- Throughput: one pixel per cycle while win_ready is held high. A consumer that holds win_ready high never causes an in_ready bubble.
- A window is consumed on a cycle with win_valid && win_ready. If a new window-producing pixel is accepted in that same cycle, win_valid stays high and win_data updates. Otherwise win_valid drops.
- in_ready is combinational from win_valid, win_ready and rst. No other path from an input to an output is combinational.
- During reset and in the cycle it is released, in_ready is 0 while rst is low. After release: in_ready = 1, win_valid = 0, frame_done = 0.

## Configuration
- **WIN_POS_EN defined:**
  - win_row and win_col exist.
  - Both register the (r,c) of the window's bottom-right pixel together with win_data.
  - Both hold under backpressure and reset to 0.
- **WIN_POS_EN undefined:** neither port exists, and no position registers beyond the col/row counters are built.

## Test plan
Pixel value = r*IMG_W + c + 1.
- **Basic window:** IMG_W = 4, IMG_H = 4, continuous in_valid, win_ready = 1 -> exactly 4 windows per frame. The first window arrives after pixel (2,2) and is {1,2,3,5,6,7,9,10,11}, k = 0..8. The last window is {6,7,8,10,11,12,14,15,16}.
- **Backpressure:** as above, but drop win_ready for 3 cycles after the first window -> win_data holds {1,...,11} and in_ready = 0 for those 3 cycles. No pixel is lost; the second window is {2,3,4,6,7,8,10,11,12}.
- **Input gaps:** toggle in_valid every other cycle -> the same 4 windows in order, and win_valid never asserts without a new window-producing accept.
- **Frame wrap:** stream 2 frames back-to-back -> frame_done pulses exactly once per frame, on the accept of pixel 16. Frame 2's first window equals frame 1's first window, with no stale rows visible.
- **Reset mid-frame:** pull rst low for 1 cycle after pixel (2,1) -> win_valid = 0 and no window from the partial frame. A fresh frame then produces the standard 4 windows.
- **WIN_POS_EN:** with the macro defined, the basic-window run shows win_row/win_col = (2,2), (2,3), (3,2), (3,3).

Source files
------------

// File: rtl/layer1_window_gen_if.sv
// -----------------------------------------------------------------------------
// layer1_window_gen_if
//
// Purpose:
//   Bundles the two streaming handshakes of the layer-1 window generator.
//   - The pixel stream comes from the fetch unit.
//   - The 3x3 window stream goes to the conv/PE array.
//   - The frame-done pulse and the optional window position are carried too.
//
// Optional feature macro: WIN_POS_EN. When defined, the interface also carries
// the row/column of each window's bottom-right pixel.
//
// Signals:
//   in_valid   pixel present on in_data                (into the block)
//   in_data    pixel value, DATA_W bits                (into the block)
//   in_ready   block can take a pixel this cycle       (out of the block)
//   win_valid  win_data holds a valid window           (out of the block)
//   win_data   packed 3x3 window, 9*DATA_W bits        (out of the block)
//   win_ready  downstream consumes the window          (into the block)
//   frame_done one-cycle pulse on last-pixel accept    (out of the block)
//   win_row    window bottom-right row    (WIN_POS_EN, out of the block)
//   win_col    window bottom-right column (WIN_POS_EN, out of the block)
//
// Modports:
//   slave  - the window generator itself
//   master - the surrounding logic: the pixel source plus the window sink
// -----------------------------------------------------------------------------
interface layer1_window_gen_if #(
   parameter int DATA_W = 16,
   parameter int IMG_W  = 32,
   parameter int IMG_H  = 32
);

   logic                  in_valid;
   logic [DATA_W-1:0]     in_data;
   logic                  in_ready;
   logic                  win_valid;
   logic [9*DATA_W-1:0]   win_data;
   logic                  win_ready;
   logic                  frame_done;
`ifdef WIN_POS_EN
   logic [$clog2(IMG_H)-1:0] win_row;
   logic [$clog2(IMG_W)-1:0] win_col;
`endif

   modport slave (
      input  in_valid, in_data, win_ready,
`ifdef WIN_POS_EN
      output win_row, win_col,
`endif
      output in_ready, win_valid, win_data, frame_done
   );

   modport master (
      output in_valid, in_data, win_ready,
`ifdef WIN_POS_EN
      input  win_row, win_col,
`endif
      input  in_ready, win_valid, win_data, frame_done
   );

endinterface : layer1_window_gen_if

// File: rtl/layer1_window_gen.sv
// -----------------------------------------------------------------------------
// layer1_window_gen
//
// Purpose:
//   Streaming 3x3 sliding-window generator. This is the read side of the
//   layer-1 line-delay stage.
//   - It accepts a raster-ordered pixel stream.
//   - It keeps the two previous image rows in line buffers lb0 (row r-1) and
//     lb1 (row r-2).
//   - It emits one packed 3x3 window for every pixel position (r,c) with
//     r >= 2 and c >= 2.
//
// Optional feature macro: WIN_POS_EN. When defined, the block registers the
// (row, col) of each window's bottom-right pixel alongside win_data.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-low reset
//   bus   layer1_window_gen_if.slave. It carries:
//         - in_valid / in_data / in_ready     pixel stream in
//         - win_valid / win_data / win_ready  window stream out
//         - frame_done                        one-cycle pulse after the last
//                                             pixel of a frame
//         - win_row / win_col                 window position (WIN_POS_EN)
//
// Window packing:
//   - Element k = 3*i + j sits at bits [(k+1)*DATA_W-1 : k*DATA_W].
//   - i = 0 is the oldest row (top); j = 0 is the leftmost column.
// -----------------------------------------------------------------------------
module layer1_window_gen #(
   parameter int DATA_W = 16,
   parameter int IMG_W  = 32,
   parameter int IMG_H  = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   layer1_window_gen_if.slave   bus
);

   localparam int COL_W = $clog2(IMG_W);
   localparam int ROW_W = $clog2(IMG_H);
   localparam int WIN_W = 9 * DATA_W;

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

   typedef logic [DATA_W-1:0] pixel_t;

   // Raster position of the next pixel to be accepted
   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;

   // Line buffers: lb0 holds row r-1 and lb1 holds row r-2, both indexed by column
   pixel_t lb0 [IMG_W];
   pixel_t lb1 [IMG_W];

   // Window register, output valid and the frame-done pulse
   logic [WIN_W-1:0] win_q;
   logic [WIN_W-1:0] win_next;
   logic             win_valid_q;
   logic             frame_done_q;

`ifdef WIN_POS_EN
   logic [ROW_W-1:0] win_row_q;
   logic [COL_W-1:0] win_col_q;
`endif

   logic   in_ready_c;
   logic   accept;
   logic   emit;
   logic   col_last;
   logic   row_last;
   pixel_t tap_top;   // row r-2 at the current column
   pixel_t tap_mid;   // row r-1 at the current column

   // ---------------------------------------------------------------------------
   // Handshake
   // ---------------------------------------------------------------------------
   // The block takes a pixel whenever the output slot is empty or being drained
   // this cycle, so a consumer holding win_ready high never stalls the input.
   assign in_ready_c = rst && (!win_valid_q || bus.win_ready);
   assign accept     = bus.in_valid && in_ready_c;

   assign col_last = (col == COL_LAST);
   assign row_last = (row == ROW_LAST);

   // Only positions with a full 3x3 neighbourhood produce a window. This mask
   // also hides stale line-buffer contents left over from an earlier frame or
   // from a frame cut short by reset.
   assign emit = accept && (row >= ROW_W'(2)) && (col >= COL_W'(2));

   // ---------------------------------------------------------------------------
   // Window shift
   // ---------------------------------------------------------------------------
   // Buffer reads use the values from before this edge's writes, so the new
   // right column is {row r-2, row r-1, incoming pixel}.
   assign tap_top = lb1[col];
   assign tap_mid = lb0[col];

   always_comb begin
      // NOTE: assign a default first so no path leaves win_next unassigned.
      //       A missing default would infer a latch.
      win_next = win_q;
      for (int i = 0; i < 3; i++) begin
         win_next[(3*i)*DATA_W   +: DATA_W] = win_q[(3*i+1)*DATA_W +: DATA_W];
         win_next[(3*i+1)*DATA_W +: DATA_W] = win_q[(3*i+2)*DATA_W +: DATA_W];
      end
      win_next[2*DATA_W +: DATA_W] = tap_top;
      win_next[5*DATA_W +: DATA_W] = tap_mid;
      win_next[8*DATA_W +: DATA_W] = bus.in_data;
   end

   // ---------------------------------------------------------------------------
   // Line buffers
   // ---------------------------------------------------------------------------
   // NOTE: the line-buffer RAM has no reset, which lets it map onto plain
   //       memory. Stale entries are harmless because emit masks them out.
   always_ff @(posedge clk) begin
      if (accept) begin
         lb1[col] <= lb0[col];
         lb0[col] <= bus.in_data;
      end
   end

   // ---------------------------------------------------------------------------
   // Counters, window register and output flags
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only. Every register
   //       then sees the pre-edge values of every other register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         col          <= '0;
         row          <= '0;
         win_q        <= '0;
         win_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         // The pulse is high only in the cycle after the last pixel is accepted
         frame_done_q <= accept && col_last && row_last;

         // A new window replaces the consumed one in the same cycle. Otherwise
         // the slot empties once downstream takes it, or holds under
         // backpressure.
         win_valid_q <= emit || (win_valid_q && !bus.win_ready);

         // Non-emitting accepts still shift the register, so the window is
         // complete by the time an emitting column arrives. Nothing shifts
         // under backpressure because accept is low then.
         if (accept) begin
            win_q <= win_next;
            if (col_last) begin
               col <= '0;
               row <= row_last ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

`ifdef WIN_POS_EN
   // Position of the window's bottom-right pixel, captured together with win_q
   always_ff @(posedge clk) begin
      if (!rst) begin
         win_row_q <= '0;
         win_col_q <= '0;
      end else if (emit) begin
         win_row_q <= row;
         win_col_q <= col;
      end
   end

   assign bus.win_row = win_row_q;
   assign bus.win_col = win_col_q;
`endif

   assign bus.in_ready   = in_ready_c;
   assign bus.win_valid  = win_valid_q;
   assign bus.win_data   = win_q;
   assign bus.frame_done = frame_done_q;

endmodule : layer1_window_gen

// File: tb/tb_layer1_window_gen.sv
// -----------------------------------------------------------------------------
// tb_layer1_window_gen
//
// Directed self-checking bench for layer1_window_gen on a 4x4 image.
// Pixel value = r*IMG_W + c + 1.
//
// Runs, in order:
//   - reset state
//   - basic frame
//   - backpressure after the first window
//   - input gaps
//   - two back-to-back frames
//   - reset in mid-frame, then a fresh frame
//
// Build with WIN_POS_EN defined to check win_row/win_col as well.
// -----------------------------------------------------------------------------
module tb_layer1_window_gen;

   localparam int DATA_W = 16;
   localparam int IMG_W  = 4;
   localparam int IMG_H  = 4;
   localparam int WIN_W  = 9 * DATA_W;
   localparam int PER_FR = (IMG_W - 2) * (IMG_H - 2);

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   layer1_window_gen_if #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) bus ();

   layer1_window_gen #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [WIN_W-1:0] data;
      int               row;
      int               col;
   } win_rec_t;

   win_rec_t got_q[$];
   int n_err = 0;
   int n_chk = 0;
   int n_acc = 0;
   int n_fd  = 0;
   int fd_pix = -1;
   int last_acc = -1;

   logic [WIN_W-1:0] first_win, second_win, last_win;

   task automatic check(input string tag, input logic [WIN_W-1:0] got,
                        input logic [WIN_W-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [WIN_W-1:0] pack9(input int a0, input int a1, input int a2,
                                              input int a3, input int a4, input int a5,
                                              input int a6, input int a7, input int a8);
      return {DATA_W'(a8), DATA_W'(a7), DATA_W'(a6), DATA_W'(a5), DATA_W'(a4),
              DATA_W'(a3), DATA_W'(a2), DATA_W'(a1), DATA_W'(a0)};
   endfunction

   // Expected window whose bottom-right pixel is (r,c)
   function automatic logic [WIN_W-1:0] exp_win(input int r, input int c);
      logic [WIN_W-1:0] w;
      w = '0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            w[(3*i+j)*DATA_W +: DATA_W] = DATA_W'((r - 2 + i) * IMG_W + (c - 2 + j) + 1);
      return w;
   endfunction

   // Monitor: samples on the falling edge, away from the active edge
   always @(negedge clk) begin
      win_rec_t rec;
      if (bus.frame_done === 1'b1) begin
         n_fd++;
         fd_pix = last_acc;
      end
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
         n_acc++;
         last_acc = int'(bus.in_data);
      end
      if (bus.win_valid === 1'b1 && bus.win_ready === 1'b1) begin
         rec.data = bus.win_data;
`ifdef WIN_POS_EN
         rec.row = int'(bus.win_row);
         rec.col = int'(bus.win_col);
`else
         rec.row = -1;
         rec.col = -1;
`endif
         got_q.push_back(rec);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      got_q.delete();
      n_acc  = 0;
      n_fd   = 0;
      fd_pix = -1;
   endtask

   task automatic send_pixel(input int val);
      bit got;
      int budget;
      got = 1'b0;
      budget = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = DATA_W'(val);
      while (!got && budget < 64) begin
         @(negedge clk);
         got = bus.in_valid && bus.in_ready;
         @(posedge clk);
         #1;
         budget++;
      end
      check($sformatf("accept_px%0d", val), got, 1);
   endtask

   // Holds win_ready low for three cycles while offering the next pixel
   task automatic hold_bp();
      bus.win_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = DATA_W'(2 * IMG_W + 3 + 1);
      for (int k = 0; k < 3; k++) begin
         #1;
         check($sformatf("bp_valid%0d", k), bus.win_valid, 1);
         check($sformatf("bp_data%0d", k), bus.win_data, first_win);
         check($sformatf("bp_in_ready%0d", k), bus.in_ready, 0);
         tick();
      end
      bus.win_ready = 1'b1;
   endtask

   task automatic stream_frame(input bit gaps, input bit bp);
      for (int r = 0; r < IMG_H; r++) begin
         for (int c = 0; c < IMG_W; c++) begin
            send_pixel(r * IMG_W + c + 1);
            if (bp && r == 2 && c == 2) hold_bp();
            if (gaps) begin
               bus.in_valid = 1'b0;
               tick();
            end
         end
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      repeat (3) tick();
      check({tag, "_idle_valid"}, bus.win_valid, 0);
   endtask

   task automatic verify(input int nframes, input string tag);
      check({tag, "_count"}, got_q.size(), PER_FR * nframes);
      check({tag, "_accepts"}, n_acc, IMG_W * IMG_H * nframes);
      for (int n = 0; n < got_q.size() && n < PER_FR * nframes; n++) begin
         int r;
         int c;
         r = 2 + (n % PER_FR) / (IMG_W - 2);
         c = 2 + (n % PER_FR) % (IMG_W - 2);
         check($sformatf("%s_win%0d", tag, n), got_q[n].data, exp_win(r, c));
`ifdef WIN_POS_EN
         check($sformatf("%s_row%0d", tag, n), got_q[n].row, r);
         check($sformatf("%s_col%0d", tag, n), got_q[n].col, c);
`endif
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      first_win  = pack9(1, 2, 3, 5, 6, 7, 9, 10, 11);
      second_win = pack9(2, 3, 4, 6, 7, 8, 10, 11, 12);
      last_win   = pack9(6, 7, 8, 10, 11, 12, 14, 15, 16);

      rst           = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.win_ready = 1'b1;

      // Reset state
      repeat (3) tick();
      check("rst_win_valid", bus.win_valid, 0);
      check("rst_frame_done", bus.frame_done, 0);
      check("rst_win_data", bus.win_data, 0);
      check("rst_in_ready", bus.in_ready, 0);
      rst = 1'b1;
      #1;
      check("rel_in_ready", bus.in_ready, 1);
      tick();

      // Basic frame
      clear_mon();
      stream_frame(1'b0, 1'b0);
      drain("basic");
      verify(1, "basic");
      check("basic_first", got_q[0].data, first_win);
      check("basic_last", got_q[PER_FR-1].data, last_win);
      check("basic_fd_count", n_fd, 1);
      check("basic_fd_pixel", fd_pix, IMG_W * IMG_H);

      // Backpressure after the first window
      clear_mon();
      stream_frame(1'b0, 1'b1);
      drain("bp");
      verify(1, "bp");
      check("bp_second", got_q[1].data, second_win);

      // Input gaps
      clear_mon();
      stream_frame(1'b1, 1'b0);
      drain("gap");
      verify(1, "gap");

      // Two frames back-to-back
      clear_mon();
      stream_frame(1'b0, 1'b0);
      stream_frame(1'b0, 1'b0);
      drain("wrap");
      verify(2, "wrap");
      check("wrap_fd_count", n_fd, 2);
      check("wrap_fd_pixel", fd_pix, IMG_W * IMG_H);
      check("wrap_f2_first", got_q[PER_FR].data, first_win);

      // Reset after pixel (2,1), then a fresh frame
      clear_mon();
      for (int p = 1; p <= 2 * IMG_W + 2; p++) send_pixel(p);
      bus.in_valid = 1'b1;
      bus.in_data  = DATA_W'(2 * IMG_W + 3);
      rst = 1'b0;
      #1;
      check("mid_rst_in_ready", bus.in_ready, 0);
      tick();
      bus.in_valid = 1'b0;
      check("mid_rst_win_valid", bus.win_valid, 0);
      check("mid_rst_win_data", bus.win_data, 0);
      check("mid_rst_frame_done", bus.frame_done, 0);
      check("mid_rst_accepts", n_acc, 2 * IMG_W + 2);
      rst = 1'b1;
      #1;
      check("mid_rel_in_ready", bus.in_ready, 1);
      tick();
      check("mid_no_window", got_q.size(), 0);
      clear_mon();
      stream_frame(1'b0, 1'b0);
      drain("fresh");
      verify(1, "fresh");
      check("fresh_first", got_q[0].data, first_win);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule : tb_layer1_window_gen
